// File: rtl/fifo_umbral.sv
// ---------------------------------------------------------------------------
// fifo_umbral
//   Synchronous single-clock FIFO with programmable almost-full and
//   almost-empty thresholds ("umbral") and an overflow/underflow error flag.
//
//   Parameters
//     DATA_SIZE   data word width in bits
//     DEPTH_LOG2  log2 of the queue depth (DEPTH = 2**DEPTH_LOG2)
//
//   Ports
//     clk               rising-edge clock
//     reset             asynchronous, active-high reset
//     write             push request
//     read              pop request
//     buff_in           push data
//     umb_almost_full   almost-full threshold  (occupancy >= threshold)
//     umb_almost_empty  almost-empty threshold (occupancy <= threshold)
//     buffer_out        popped data, registered, held between reads
//     data_count        current occupancy (registered)
//     fifo_full         occupancy == DEPTH
//     fifo_empty        occupancy == 0
//     almost_full       occupancy >= umb_almost_full
//     almost_empty      occupancy <= umb_almost_empty
//     error             overflow/underflow indication
//
//   Build option
//     FIFO_ERR_STICKY_EN  defined:   error latches on any overflow/underflow
//                                    event and holds until reset.
//                         undefined: error is a one-cycle registered pulse
//                                    in the cycle after each event.
//
//   Storage is not cleared by reset; only pointers, count, buffer_out and
//   error are.
// ---------------------------------------------------------------------------
module fifo_umbral #(
  parameter int unsigned DATA_SIZE  = 6,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write,
  input  logic                  read,
  input  logic [DATA_SIZE-1:0]  buff_in,
  input  logic [DEPTH_LOG2:0]   umb_almost_full,
  input  logic [DEPTH_LOG2:0]   umb_almost_empty,
  output logic [DATA_SIZE-1:0]  buffer_out,
  output logic [DEPTH_LOG2:0]   data_count,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error
);

  localparam int unsigned             DEPTH      = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]     COUNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]     COUNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0]   PTR_ONE    = DEPTH_LOG2'(1);

  logic [DATA_SIZE-1:0]  mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;

  logic rd_ok;
  logic wr_ok;
  logic overflow;
  logic underflow;
  logic err_event;

  // -------------------------------------------------------------------------
  // Status flags: purely combinational from the registered count and the
  // live threshold inputs. Thresholds are compared unsigned without clamping.
  // -------------------------------------------------------------------------
  always_comb begin
    fifo_full    = (data_count == COUNT_FULL);
    fifo_empty   = (data_count == '0);
    almost_full  = (data_count >= umb_almost_full);
    almost_empty = (data_count <= umb_almost_empty);
  end

  // -------------------------------------------------------------------------
  // Operation qualification.
  //   A read succeeds whenever there is data.
  //   A write succeeds when there is room, or when the FIFO is full but a
  //   read frees a slot in the same cycle.
  //   Reading an empty FIFO is an underflow even if a write is accepted in
  //   the same cycle; writing a full FIFO without a read is an overflow.
  // -------------------------------------------------------------------------
  always_comb begin
    rd_ok     = read && !fifo_empty;
    wr_ok     = write && (!fifo_full || rd_ok);
    overflow  = write && fifo_full && !read;
    underflow = read && fifo_empty;
    err_event = overflow || underflow;
  end

  // -------------------------------------------------------------------------
  // Storage array: no reset, so it is kept in its own clocked process.
  // Writes are suppressed while reset is asserted so the array cannot be
  // disturbed by a push request that arrives during reset.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset && wr_ok) begin
      mem[wr_ptr] <= buff_in;
    end
  end

  // -------------------------------------------------------------------------
  // Pointers: wrap naturally from DEPTH-1 to 0 through their width.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Occupancy: changes only when exactly one side succeeds.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_count <= '0;
    end else begin
      if (wr_ok && !rd_ok) begin
        data_count <= data_count + COUNT_ONE;
      end else if (rd_ok && !wr_ok) begin
        data_count <= data_count - COUNT_ONE;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output data register: loaded only on a successful read, held otherwise.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buffer_out <= '0;
    end else if (rd_ok) begin
      buffer_out <= mem[rd_ptr];
    end
  end

  // -------------------------------------------------------------------------
  // Error flag.
  // -------------------------------------------------------------------------
`ifdef FIFO_ERR_STICKY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      error <= 1'b0;
    end else if (err_event) begin
      error <= 1'b1;
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      error <= 1'b0;
    end else begin
      error <= err_event;
    end
  end
`endif

endmodule

// File: doc/fifo_umbral.md
FIFO_UMBRAL -- requirements
Module: fifo_umbral

Interface
REQ-001 The block SHALL have parameter DATA_SIZE, default 6, setting the data word width in bits.
REQ-002 The block SHALL have parameter DEPTH_LOG2, default 3, setting the queue depth DEPTH = 2^DEPTH_LOG2 (8 entries).
REQ-003 The block SHALL have these ports, one clock, with asynchronous active-high reset:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high
- write  input  1  push request
- read  input  1  pop request
- buff_in  input  DATA_SIZE  push data
- umb_almost_full  input  DEPTH_LOG2+1  almost-full threshold
- umb_almost_empty  input  DEPTH_LOG2+1  almost-empty threshold
- buffer_out  output  DATA_SIZE  popped data (registered)
- data_count  output  DEPTH_LOG2+1  current occupancy
- fifo_full  output  1  occupancy == DEPTH
- fifo_empty  output  1  occupancy == 0
- almost_full  output  1  occupancy >= umb_almost_full
- almost_empty  output  1  occupancy <= umb_almost_empty
- error  output  1  overflow/underflow indication

Function
REQ-004 Storage SHALL be DEPTH words of DATA_SIZE bits, addressed by write and read pointers of DEPTH_LOG2 bits that wrap from DEPTH-1 to 0.
REQ-005 A write with fifo_full=0 SHALL store buff_in at the write pointer and advance the pointer on that rising edge.
REQ-006 A read with fifo_empty=0 SHALL load the word at the read pointer into buffer_out on that rising edge (latency 1) and advance the pointer.
REQ-007 buffer_out SHALL hold its value in every cycle without a successful read.
REQ-008 data_count SHALL be a register: +1 on a write-only success, -1 on a read-only success, unchanged on simultaneous success or no operation.
REQ-009 fifo_full, fifo_empty, almost_full and almost_empty SHALL be combinational from the registered data_count and the current threshold inputs.
REQ-010 A write while full with read=0 SHALL be dropped: memory, pointer and count are unchanged and an overflow event is raised.
REQ-011 A read while empty SHALL be ignored: buffer_out and pointers are unchanged and an underflow event is raised.
REQ-012 Simultaneous read and write while full SHALL both succeed, with count remaining DEPTH.
REQ-013 Simultaneous read and write while empty SHALL perform the write only, set count to 1, and raise an underflow event.
REQ-014 Thresholds SHALL be compared unsigned, with no internal clamping; for example, umb_almost_full=0 gives almost_full=1 permanently.

Reset
REQ-015 Asserting reset SHALL immediately, independent of clk, set both pointers to 0, data_count=0, buffer_out=0 and error=0.
REQ-016 Memory contents SHALL NOT be cleared by reset.
REQ-017 Reset asserted mid-operation SHALL discard all queued data; after reset, fifo_empty=1, almost_empty=1 and fifo_full=0.
REQ-018 The first operation after reset SHALL be accepted on the first rising edge at which reset is low.

Configuration
REQ-019 Macro FIFO_ERR_STICKY_EN SHALL select the error behaviour:
- Defined: error is set by any overflow or underflow event and held at 1 until reset.
- Undefined: error is a registered one-cycle pulse, high for exactly the cycle after each event and 0 otherwise.

Verification
REQ-020 Scenario: reset high, then released -> buffer_out=0, data_count=0, fifo_empty=1, almost_empty=1, error=0.
REQ-021 Scenario: with thresholds 3 and 6, write 8 words 0x03..0x0A on consecutive cycles ->
- data_count steps 1..8
- almost_empty drops when count=4
- almost_full rises when count=6
- fifo_full=1 at count=8
- error=0 throughout
REQ-022 Scenario: FIFO full, write 0x0B alone -> count stays 8, word dropped, error=1 the next cycle (one cycle only without the macro).
REQ-023 Scenario: FIFO full, read 8 consecutive cycles -> buffer_out sequence 0x03..0x0A, each one cycle after its read, count reaches 0 and fifo_empty=1.
REQ-024 Scenario: FIFO empty, read and write 0x15 in the same cycle -> count=1, buffer_out unchanged, error raised; a following read returns 0x15.
REQ-025 Scenario: with the write pointer at 6, write 4 words and read 4 words -> pointers wrap, data is returned in order, count returns to its starting value.
